// File: rtl/io_sel_ctrl.sv
// Routing-word owner for the PulseCounter input switch.
// Shadow table of pin selections, committed atomically on a sample_tick boundary.
module io_sel_ctrl #(
  parameter int INPUT_WIDTH  = 20,
  parameter int TICK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_ch,
  input  logic        wr_side,
  input  logic [4:0]  wr_pin,
  input  logic        commit,
  input  logic        abort,
  input  logic        sample_tick,
  input  logic        err_clr,
  output logic        busy,
  output logic        pending,
  output logic        commit_done,
  output logic        err,
  output logic        tmo,
  output logic [32:0] IO_Sel0,
  output logic [32:0] IO_Sel1,
  output logic [32:0] IO_Sel2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STAGED,
    S_WAIT,
    S_APPLY
  } state_t;

  localparam int CW = (TICK_TIMEOUT > 2) ? $clog2(TICK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TICK_TIMEOUT - 1);
  localparam logic [5:0] IW = 6'(INPUT_WIDTH);

  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [4:0] sh_a [8];
  logic [4:0] sh_b [8];
  logic [4:0] act_a [8];
  logic [4:0] act_b [8];
  logic [32:0] io_w [3];

  logic wr_fire, pin_ok;
  logic do_wr, bad_wr, do_abort, do_apply;
  logic tmo_set, tmo_drop, cnt_clr;

  assign wr_ready = (st == S_IDLE) || (st == S_STAGED);
  assign busy     = (st == S_WAIT) || (st == S_APPLY);
  assign pending  = (st == S_STAGED);
  assign wr_fire  = wr_valid && wr_ready;
  assign pin_ok   = {1'b0, wr_pin} < IW;

  // Next-state and per-cycle control; abort beats commit beats write.
  always_comb begin
    nxt      = st;
    do_wr    = 1'b0;
    bad_wr   = 1'b0;
    do_abort = 1'b0;
    do_apply = 1'b0;
    tmo_set  = 1'b0;
    tmo_drop = 1'b0;
    cnt_clr  = 1'b0;
    unique case (st)
      S_IDLE, S_STAGED: begin
        if (abort) begin
          do_abort = 1'b1;
          nxt      = S_IDLE;
        end else begin
          do_wr  = wr_fire && pin_ok;
          bad_wr = wr_fire && !pin_ok;
          if (commit) begin
            nxt      = S_WAIT;
            cnt_clr  = 1'b1;
            tmo_drop = 1'b1;
          end else if (do_wr) begin
            nxt = S_STAGED;
          end
        end
      end
      S_WAIT: begin
        if (abort) begin
          do_abort = 1'b1;
          nxt      = S_IDLE;
        end else if (sample_tick) begin
          nxt = S_APPLY;
        end else if (TICK_TIMEOUT != 0 && cnt == TMO_LAST) begin
          nxt     = S_APPLY;
          tmo_set = 1'b1;
        end
      end
      S_APPLY: begin
        do_apply = 1'b1;
        nxt      = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) st <= S_IDLE;
    else       st <= nxt;
  end

  // Tick-wait counter, restarted on each commit.
  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (cnt_clr)      cnt <= '0;
    else if (st == S_WAIT) cnt <= cnt + 1'b1;
  end

  // Shadow and active route tables.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        sh_a[k]  <= 5'(2 * k);
        sh_b[k]  <= 5'(2 * k + 1);
        act_a[k] <= 5'(2 * k);
        act_b[k] <= 5'(2 * k + 1);
      end
    end else begin
      if (do_abort) begin
        for (int k = 0; k < 8; k++) begin
          sh_a[k] <= act_a[k];
          sh_b[k] <= act_b[k];
        end
      end else if (do_wr) begin
        if (wr_side) sh_b[wr_ch] <= wr_pin;
        else         sh_a[wr_ch] <= wr_pin;
      end
      if (do_apply) begin
        for (int k = 0; k < 8; k++) begin
          act_a[k] <= sh_a[k];
          act_b[k] <= sh_b[k];
        end
      end
    end
  end

  // Status flags; a set in the same cycle beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_done <= 1'b0;
      err         <= 1'b0;
      tmo         <= 1'b0;
    end else begin
      commit_done <= do_apply;
      if (bad_wr)       err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (tmo_set)                   tmo <= 1'b1;
      else if (err_clr || tmo_drop)  tmo <= 1'b0;
    end
  end

  // Pack active routes: channel k -> word k/3, slot k%3, CHA low, CHB high.
  always_comb begin
    for (int w = 0; w < 3; w++) io_w[w] = '0;
    for (int k = 0; k < 8; k++) begin
      io_w[k/3][10*(k%3) +: 5]     = act_a[k];
      io_w[k/3][10*(k%3) + 5 +: 5] = act_b[k];
    end
  end

  assign IO_Sel0 = io_w[0];
  assign IO_Sel1 = io_w[1];
  assign IO_Sel2 = io_w[2];

endmodule

// File: tb/tb_io_sel_ctrl.sv
// Bench for io_sel_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural route-table model.
module tb_io_sel_ctrl;

  localparam int IW = 20;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset, wr_valid, wr_side, commit, abort, sample_tick, err_clr;
  logic [2:0] wr_ch;
  logic [4:0] wr_pin;
  logic wr_ready, busy, pending, commit_done, err, tmo;
  logic [32:0] IO_Sel0, IO_Sel1, IO_Sel2;

  int n_cmp = 0;
  int n_bad = 0;

  io_sel_ctrl #(.INPUT_WIDTH(IW), .TICK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_side(wr_side), .wr_pin(wr_pin),
    .commit(commit), .abort(abort), .sample_tick(sample_tick),
    .err_clr(err_clr), .busy(busy), .pending(pending),
    .commit_done(commit_done), .err(err), .tmo(tmo),
    .IO_Sel0(IO_Sel0), .IO_Sel1(IO_Sel1), .IO_Sel2(IO_Sel2)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 staged, 2 waiting for tick, 3 applying.
  int m_a [8];
  int m_b [8];
  int s_a [8];
  int s_b [8];
  int ph, entry, ncyc;
  bit m_cd, m_err, m_tmo, mvalid;

  initial begin
    mvalid = 0;
    ncyc   = 0;
  end

  function automatic logic [32:0] pack(input int w);
    logic [32:0] v = '0;
    for (int k = 0; k < 8; k++)
      if (k / 3 == w) begin
        v += 33'(m_a[k]) << (10 * (k % 3));
        v += 33'(m_b[k]) << (10 * (k % 3) + 5);
      end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [32:0] a,
                     input logic [32:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, a, e);
    end
  endtask

  always @(posedge clk) begin
    bit wrote, err_s, tmo_s, tmo_c;
    ncyc++;
    wrote = 0; err_s = 0; tmo_s = 0; tmo_c = 0;
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        m_a[k] = 2 * k;  m_b[k] = 2 * k + 1;
        s_a[k] = 2 * k;  s_b[k] = 2 * k + 1;
      end
      ph = 0; m_cd = 0; m_err = 0; m_tmo = 0;
      mvalid = 1;
    end else if (mvalid) begin
      m_cd = 0;
      if (ph == 0 || ph == 1) begin
        if (abort) begin
          s_a = m_a; s_b = m_b; ph = 0;
        end else begin
          if (wr_valid) begin
            if (int'(wr_pin) < IW) begin
              if (wr_side) s_b[wr_ch] = int'(wr_pin);
              else         s_a[wr_ch] = int'(wr_pin);
              wrote = 1;
            end else err_s = 1;
          end
          if (commit) begin
            ph = 2; entry = ncyc; tmo_c = 1;
          end else if (wrote) ph = 1;
        end
      end else if (ph == 2) begin
        if (abort) begin
          s_a = m_a; s_b = m_b; ph = 0;
        end else if (sample_tick) ph = 3;
        else if (TO != 0 && ncyc - entry == TO) begin
          ph = 3; tmo_s = 1;
        end
      end else begin
        m_a = s_a; m_b = s_b; m_cd = 1; ph = 0;
      end
      if (err_clr) begin m_err = 0; m_tmo = 0; end
      if (tmo_c) m_tmo = 0;
      if (err_s) m_err = 1;
      if (tmo_s) m_tmo = 1;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("io_sel0", IO_Sel0, pack(0));
      chk("io_sel1", IO_Sel1, pack(1));
      chk("io_sel2", IO_Sel2, pack(2));
      chk("wr_ready", 33'(wr_ready), 33'(ph <= 1));
      chk("busy", 33'(busy), 33'(ph >= 2));
      chk("pending", 33'(pending), 33'(ph == 1));
      chk("commit_done", 33'(commit_done), 33'(m_cd));
      chk("err", 33'(err), 33'(m_err));
      chk("tmo", 33'(tmo), 33'(m_tmo));
    end
  end

  task automatic idle();
    wr_valid = 0; wr_ch = '0; wr_side = 0; wr_pin = '0;
    commit = 0; abort = 0; sample_tick = 0; err_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int ch, input bit side, input int pin);
    wr_valid = 1; wr_ch = 3'(ch); wr_side = side; wr_pin = 5'(pin);
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    reset = 0;
    chk("rst_sel0", IO_Sel0, 33'h0_0A41_8820);
    chk("rst_sel1", IO_Sel1, 33'h0_16A4_A0E6);
    chk("rst_sel2", IO_Sel2, 33'h0_0007_B9AC);
    chk("rst_pending", 33'(pending), 33'd0);
    chk("rst_wr_ready", 33'(wr_ready), 33'd1);

    wr(4, 1, 19); step(); idle();
    chk("s1_pending", 33'(pending), 33'd1);
    commit = 1; step(); idle();
    chk("s1_busy", 33'(busy), 33'd1);
    repeat (4) step();
    sample_tick = 1; step(); idle();
    chk("s1_apply_old", 33'(IO_Sel1[19:15]), 33'd9);
    chk("s1_apply_cd", 33'(commit_done), 33'd0);
    step();
    chk("s1_new", 33'(IO_Sel1[19:15]), 33'd19);
    chk("s1_cd", 33'(commit_done), 33'd1);

    wr(2, 0, 25); step(); idle();
    chk("s2_err", 33'(err), 33'd1);
    chk("s2_pending", 33'(pending), 33'd0);
    chk("s2_sel0", IO_Sel0, 33'h0_0A41_8820);
    err_clr = 1; step(); idle();
    chk("s2_clr", 33'(err), 33'd0);

    wr(0, 0, 7); step(); idle();
    commit = 1; step(); idle();
    abort = 1; step(); idle();
    chk("s3_busy", 33'(busy), 33'd0);
    chk("s3_sel0", IO_Sel0, 33'h0_0A41_8820);
    commit = 1; step(); idle();
    sample_tick = 1; step(); idle();
    step();
    chk("s3_cd", 33'(commit_done), 33'd1);
    chk("s3_sel0b", IO_Sel0, 33'h0_0A41_8820);

    commit = 1; step(); idle();
    repeat (15) step();
    chk("s4_wait", 33'(busy), 33'd1);
    chk("s4_notmo", 33'(tmo), 33'd0);
    step();
    chk("s4_tmo", 33'(tmo), 33'd1);
    chk("s4_cd0", 33'(commit_done), 33'd0);
    step();
    chk("s4_cd1", 33'(commit_done), 33'd1);
    err_clr = 1; step(); idle();
    chk("s4_clr", 33'(tmo), 33'd0);

    wr(6, 1, 3); commit = 1; step();
    commit = 0; wr(6, 1, 17);
    chk("s5_stall", 33'(wr_ready), 33'd0);
    sample_tick = 1; step(); sample_tick = 0;
    chk("s5_stall2", 33'(wr_ready), 33'd0);
    step();
    chk("s5_first", 33'(IO_Sel2[9:5]), 33'd3);
    chk("s5_ready", 33'(wr_ready), 33'd1);
    step(); idle();
    chk("s5_second", 33'(pending), 33'd1);

    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      wr_valid    = ($urandom_range(0, 9) < 4);
      wr_ch       = 3'($urandom_range(0, 7));
      wr_side     = 1'($urandom_range(0, 1));
      wr_pin      = 5'($urandom_range(0, 31));
      commit      = ($urandom_range(0, 9) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      sample_tick = ($urandom_range(0, 24) == 0);
      err_clr     = ($urandom_range(0, 19) == 0);
      step();
    end
    reset = 0;
    idle();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
